// File: rtl/key_action_decoder_pkg.sv
// Shared keycodes, action FSM states and a small sizing helper for the HID key action decoder.
package hk_input_pkg;

    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_D = 8'h07;
    localparam logic [7:0] KEY_W = 8'h1A;
    localparam logic [7:0] KEY_J = 8'h0D;
    localparam logic [7:0] KEY_K = 8'h0E;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        COOL   = 2'd2
    } action_state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_action_decoder_action_timer.sv
// Frame-counted action window followed by a cooldown; presses outside IDLE are discarded.
module action_timer
    import hk_input_pkg::*;
#(
    parameter int FRAMES   = 6,
    parameter int COOLDOWN = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic start,
    input  logic block,
    output logic active,
    output logic busy,
    output logic holding
);

    localparam int CW = $clog2(max2(FRAMES, COOLDOWN) + 2);

    action_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          launch;
    logic          done;

    // A press arriving in the frame right after the last cooldown frame may relaunch at once.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        launch  = start & ~block;
        done    = 1'b0;
        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (launch) begin
                        state_d = ACTIVE;
                        cnt_d   = CW'(FRAMES);
                    end
                end
                ACTIVE: begin
                    if (cnt_q == CW'(1)) begin
                        if (COOLDOWN == 0) begin
                            done = 1'b1;
                        end else begin
                            state_d = COOL;
                            cnt_d   = CW'(COOLDOWN);
                        end
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                COOL: begin
                    if (cnt_q == CW'(1)) begin
                        done = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: done = 1'b1;
            endcase
            if (done) begin
                if (launch) begin
                    state_d = ACTIVE;
                    cnt_d   = CW'(FRAMES);
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign active  = (state_q == ACTIVE);
    assign busy    = (state_q != IDLE);
    // Still active in the coming frame; used to lock out the other action without a comb loop.
    assign holding = (state_q == ACTIVE) && (cnt_q != CW'(1));

endmodule

// File: rtl/key_action_decoder_frame_tick_gen.sv
// Synchronises the active-low VGA vsync and emits a registered one-clock pulse on its rising edge.
module frame_tick_gen (
    input  logic clk,
    input  logic reset,
    input  logic vs,
    output logic frame_tick
);

    logic sync1_q, sync1_d;
    logic sync_vs_q, sync_vs_d;
    logic sync_vs_dly_q, sync_vs_dly_d;
    logic tick_q, tick_d;

    // The edge pulse is registered so the pin-to-pulse latency is three clocks.
    always_comb begin
        sync1_d       = vs;
        sync_vs_d     = sync1_q;
        sync_vs_dly_d = sync_vs_q;
        tick_d        = sync_vs_q & ~sync_vs_dly_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q       <= 1'b0;
            sync_vs_q     <= 1'b0;
            sync_vs_dly_q <= 1'b0;
            tick_q        <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            sync_vs_q     <= sync_vs_d;
            sync_vs_dly_q <= sync_vs_dly_d;
            tick_q        <= tick_d;
        end
    end

    assign frame_tick = tick_q;

endmodule

// File: rtl/key_action_decoder.sv
// Turns the raw HID keycode into frame-aligned movement, jump, attack and dash commands.
module key_action_decoder
    import hk_input_pkg::*;
#(
    parameter int ATTACK_FRAMES   = 6,
    parameter int ATTACK_COOLDOWN = 10,
    parameter int DASH_FRAMES     = 8,
    parameter int DASH_COOLDOWN   = 30,
    parameter int JUMP_HOLD_MAX   = 12
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic       vs,
    output logic       frame_tick,
    output logic       move_left,
    output logic       move_right,
    output logic       facing_left,
    output logic       jump_start,
    output logic       jump_hold,
    output logic       attack_active,
    output logic       dash_active,
    output logic       busy
);

    localparam int HW = $clog2(JUMP_HOLD_MAX + 2);

    logic [7:0]    key_q, key_d;
    logic [7:0]    key_prev_q, key_prev_d;
    logic          primed_q, primed_d;
    logic          facing_q, facing_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          tick;
    logic          attack_press, dash_press;
    logic          attack_busy, dash_busy;
    logic          attack_holding, dash_holding;

    frame_tick_gen u_tick (
        .clk        (Clk),
        .reset      (Reset),
        .vs         (vs),
        .frame_tick (tick)
    );

    // The first frame after reset copies the key into key_prev so a held key is not a press.
    always_comb begin
        key_d        = key_q;
        key_prev_d   = key_prev_q;
        primed_d     = primed_q;
        facing_d     = facing_q;
        hold_cnt_d   = hold_cnt_q;
        attack_press = tick && primed_q && (keycode == KEY_J) && (key_q != KEY_J);
        dash_press   = tick && primed_q && (keycode == KEY_K) && (key_q != KEY_K);
        if (tick) begin
            key_d      = keycode;
            key_prev_d = primed_q ? key_q : keycode;
            primed_d   = 1'b1;
            if (keycode == KEY_A) begin
                facing_d = 1'b1;
            end else if (keycode == KEY_D) begin
                facing_d = 1'b0;
            end
            if (keycode != KEY_W) begin
                hold_cnt_d = '0;
            end else if (!primed_q) begin
                hold_cnt_d = HW'(JUMP_HOLD_MAX + 1);
            end else if (key_q != KEY_W) begin
                hold_cnt_d = HW'(1);
            end else if (hold_cnt_q != HW'(JUMP_HOLD_MAX + 1)) begin
                hold_cnt_d = hold_cnt_q + HW'(1);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            key_q      <= '0;
            key_prev_q <= '0;
            primed_q   <= 1'b0;
            facing_q   <= 1'b0;
            hold_cnt_q <= '0;
        end else begin
            key_q      <= key_d;
            key_prev_q <= key_prev_d;
            primed_q   <= primed_d;
            facing_q   <= facing_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    action_timer #(
        .FRAMES   (ATTACK_FRAMES),
        .COOLDOWN (ATTACK_COOLDOWN)
    ) u_attack (
        .clk     (Clk),
        .reset   (Reset),
        .tick    (tick),
        .start   (attack_press),
        .block   (dash_holding),
        .active  (attack_active),
        .busy    (attack_busy),
        .holding (attack_holding)
    );

    action_timer #(
        .FRAMES   (DASH_FRAMES),
        .COOLDOWN (DASH_COOLDOWN)
    ) u_dash (
        .clk     (Clk),
        .reset   (Reset),
        .tick    (tick),
        .start   (dash_press),
        .block   (attack_holding),
        .active  (dash_active),
        .busy    (dash_busy),
        .holding (dash_holding)
    );

    assign frame_tick  = tick;
    assign move_left   = (key_q == KEY_A);
    assign move_right  = (key_q == KEY_D);
    assign facing_left = facing_q;
    assign jump_start  = (key_q == KEY_W) && (key_prev_q != KEY_W);
    assign jump_hold   = (key_q == KEY_W) && (hold_cnt_q <= HW'(JUMP_HOLD_MAX));
    assign busy        = attack_busy | dash_busy;

endmodule

// File: tb/tb_key_action_decoder.sv
// Self-checking bench: vector table, hand-built corner sequences and a frame-level reference model.
module tb_key_action_decoder;
    import hk_input_pkg::*;

    localparam int AF = 6;
    localparam int AC = 10;
    localparam int DF = 8;
    localparam int DC = 30;
    localparam int HM = 12;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [7:0] keycode;
    logic       vs;
    logic       frame_tick, move_left, move_right, facing_left;
    logic       jump_start, jump_hold, attack_active, dash_active, busy;

    int checks = 0;
    int errors = 0;
    int lastLatency;

    // Frame-level reference state: start frames of each action instead of counters.
    int         frameNo;
    logic [7:0] curKey, prevKey;
    bit         primed, facing, wValid;
    int         wPress, atkStart, dashStart;

    typedef struct {
        logic [7:0] key;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs[10];

    always #5 Clk = ~Clk;

    key_action_decoder #(
        .ATTACK_FRAMES   (AF),
        .ATTACK_COOLDOWN (AC),
        .DASH_FRAMES     (DF),
        .DASH_COOLDOWN   (DC),
        .JUMP_HOLD_MAX   (HM)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .keycode       (keycode),
        .vs            (vs),
        .frame_tick    (frame_tick),
        .move_left     (move_left),
        .move_right    (move_right),
        .facing_left   (facing_left),
        .jump_start    (jump_start),
        .jump_hold     (jump_hold),
        .attack_active (attack_active),
        .dash_active   (dash_active),
        .busy          (busy)
    );

    function automatic void modelReset();
        frameNo   = 0;
        curKey    = 8'h00;
        prevKey   = 8'h00;
        primed    = 1'b0;
        facing    = 1'b0;
        wValid    = 1'b0;
        wPress    = 0;
        atkStart  = -1000;
        dashStart = -1000;
    endfunction

    function automatic void modelFrame(input logic [7:0] k);
        bit atkBusyNow, dashBusyNow, atkActNow, dashActNow;
        frameNo = frameNo + 1;
        prevKey = primed ? curKey : k;
        primed  = 1'b1;
        curKey  = k;
        if (k == KEY_A) facing = 1'b1;
        else if (k == KEY_D) facing = 1'b0;
        if (k == KEY_W && prevKey != KEY_W) begin
            wPress = frameNo;
            wValid = 1'b1;
        end else if (k != KEY_W) begin
            wValid = 1'b0;
        end
        atkBusyNow  = (frameNo - atkStart) < (AF + AC);
        dashBusyNow = (frameNo - dashStart) < (DF + DC);
        atkActNow   = (frameNo - atkStart) < AF;
        dashActNow  = (frameNo - dashStart) < DF;
        if (k == KEY_J && prevKey != KEY_J && !atkBusyNow && !dashActNow) atkStart = frameNo;
        if (k == KEY_K && prevKey != KEY_K && !dashBusyNow && !atkActNow) dashStart = frameNo;
    endfunction

    function automatic logic [7:0] modelOut();
        int da = frameNo - atkStart;
        int dd = frameNo - dashStart;
        return {curKey == KEY_A, curKey == KEY_D, facing,
                (curKey == KEY_W) && (prevKey != KEY_W),
                (curKey == KEY_W) && wValid && ((frameNo - wPress) < HM),
                da < AF, dd < DF, (da < AF + AC) || (dd < DF + DC)};
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] exp);
        logic [7:0] act;
        act = {move_left, move_right, facing_left, jump_start, jump_hold,
               attack_active, dash_active, busy};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: outputs %b, expected %b", name, act, exp);
        end
    endtask

    task automatic checkValue(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic checkModel(input string name);
        checkOutput(name, modelOut());
    endtask

    task automatic doReset();
        @(negedge Clk);
        Reset = 1'b1;
        vs    = 1'b0;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        modelReset();
    endtask

    // One frame: pulse vs low, raise it, wait for the tick, then sample after the tick edge.
    task automatic applyStimulus(input logic [7:0] k);
        bit gotTick;
        @(negedge Clk);
        keycode = k;
        vs      = 1'b0;
        repeat (3) @(negedge Clk);
        vs          = 1'b1;
        lastLatency = 0;
        gotTick     = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge Clk);
            #1;
            lastLatency++;
            if (frame_tick) begin
                gotTick = 1'b1;
                break;
            end
        end
        if (!gotTick) begin
            checks++;
            errors++;
            $display("[TB] FAIL frame_tick_timeout: no tick within 10 clocks, expected one");
        end
        @(posedge Clk);
        #1;
        modelFrame(k);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [7:0] k;
        logic [7:0] pool[7];
        int         ticksSeen;

        Reset   = 1'b1;
        keycode = KEY_A;
        vs      = 1'b0;
        modelReset();

        vecs[0] = '{KEY_A, 8'b1010_0000};
        vecs[1] = '{KEY_A, 8'b1010_0000};
        vecs[2] = '{KEY_D, 8'b0100_0000};
        vecs[3] = '{8'h00, 8'b0000_0000};
        vecs[4] = '{KEY_W, 8'b0001_1000};
        vecs[5] = '{KEY_W, 8'b0000_1000};
        vecs[6] = '{KEY_J, 8'b0000_0101};
        vecs[7] = '{KEY_K, 8'b0000_0101};
        vecs[8] = '{8'h00, 8'b0000_0101};
        vecs[9] = '{KEY_A, 8'b1010_0101};

        // Reset state and the vector table.
        repeat (3) @(posedge Clk);
        #1;
        checkOutput("reset_state", 8'h00);
        @(negedge Clk);
        Reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].key);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp);
            checkModel($sformatf("vec%0d_model", i));
        end

        // Jump hold capping over a 20-frame hold, then a re-press.
        doReset();
        applyStimulus(8'h00);
        for (int f = 1; f <= 20; f++) begin
            applyStimulus(KEY_W);
            checkValue($sformatf("jump_start_f%0d", f), int'(jump_start), (f == 1) ? 1 : 0);
            checkValue($sformatf("jump_hold_f%0d", f), int'(jump_hold), (f <= HM) ? 1 : 0);
            checkModel($sformatf("jump_model_f%0d", f));
        end
        applyStimulus(8'h00);
        checkValue("jump_release_hold", int'(jump_hold), 0);
        applyStimulus(KEY_W);
        checkValue("jump_repress_start", int'(jump_start), 1);
        checkValue("jump_repress_hold", int'(jump_hold), 1);

        // Attack window, discarded press, relaunch right after cooldown.
        doReset();
        applyStimulus(8'h00);
        for (int f = 1; f <= 18; f++) begin
            k = (f == 1 || f == 4 || f == 17) ? KEY_J : 8'h00;
            applyStimulus(k);
            checkValue($sformatf("attack_active_f%0d", f), int'(attack_active),
                       (f <= AF || f >= AF + AC + 1) ? 1 : 0);
            checkValue($sformatf("attack_busy_f%0d", f), int'(busy), 1);
            checkModel($sformatf("attack_model_f%0d", f));
        end

        // Dash locked out during attack, allowed in the first attack cooldown frame.
        doReset();
        applyStimulus(8'h00);
        for (int f = 1; f <= 16; f++) begin
            k = (f == 1) ? KEY_J : (f == 2 || f == 7) ? KEY_K : 8'h00;
            applyStimulus(k);
            checkValue($sformatf("dash_active_f%0d", f), int'(dash_active),
                       (f >= 7 && f <= 7 + DF - 1) ? 1 : 0);
            checkValue($sformatf("dash_attack_f%0d", f), int'(attack_active), (f <= AF) ? 1 : 0);
            checkModel($sformatf("dash_model_f%0d", f));
        end

        // Mid-frame keycode glitch is invisible; latency and pulse width of frame_tick.
        doReset();
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        ticksSeen = 0;
        @(negedge Clk);
        keycode = KEY_J;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clk);
            if (frame_tick) ticksSeen++;
        end
        keycode = 8'h00;
        checkValue("glitch_no_tick", ticksSeen, 0);
        checkModel("glitch_outputs_held");
        applyStimulus(8'h00);
        checkValue("glitch_no_attack", int'(attack_active), 0);
        checkValue("vs_to_tick_latency", lastLatency, 3);
        checkValue("tick_single_clock", int'(frame_tick), 0);
        checkModel("glitch_model");

        // Reset during a dash, J held across reset release.
        doReset();
        applyStimulus(8'h00);
        applyStimulus(KEY_K);
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        checkValue("dash_f3_active", int'(dash_active), 1);
        @(negedge Clk);
        Reset   = 1'b1;
        keycode = KEY_J;
        @(posedge Clk);
        #1;
        checkValue("reset_abort_dash", int'(dash_active), 0);
        checkValue("reset_abort_busy", int'(busy), 0);
        vs = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        modelReset();
        applyStimulus(KEY_J);
        checkValue("held_j_f1", int'(attack_active), 0);
        applyStimulus(KEY_J);
        checkValue("held_j_f2", int'(attack_active), 0);
        applyStimulus(8'h00);
        applyStimulus(KEY_J);
        checkValue("repressed_j", int'(attack_active), 1);
        checkModel("repressed_j_model");

        // Randomised frames against the reference model.
        pool[0] = 8'h00; pool[1] = KEY_A; pool[2] = KEY_D; pool[3] = KEY_W;
        pool[4] = KEY_J; pool[5] = KEY_K; pool[6] = 8'h00;
        doReset();
        k = 8'h00;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 79) == 0) doReset();
            if ($urandom_range(0, 9) >= 4) begin
                if ($urandom_range(0, 9) == 0) k = 8'($urandom);
                else k = pool[$urandom_range(0, 6)];
            end
            applyStimulus(k);
            checkModel($sformatf("random_%0d_key%02h", n, k));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
